// File: rtl/hue_pkg.sv
// Shared types for the hue sweep: colour-wheel phases and sweep FSM states.
// Also provides phase_next(), the wrapping 0..5 phase successor.
package hue_pkg;

    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } phase_t;

    typedef enum logic {
        ST_RAMP  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    function automatic phase_t phase_next(input phase_t p);
        return (p == PH_B_DN) ? PH_G_UP : phase_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/hue_sweep_tick_prescaler.sv
// Enable-gated prescaler: pulses tick once every TICK_CYCLES enabled clocks.
// Ports: clk, rst_n (async, active-low), enable (freezes count when low), tick.
module tick_prescaler #(
    parameter int TICK_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hue_sweep.sv
// Six-phase colour-wheel duty source for three RGB pwm channels.
// Ports: clk, rst_n (async, active-low), enable; duty_r/g/b, phase, wrap out.
// Optional HUE_DWELL_EN: hold each phase end for DWELL_TICKS extra ticks.
module hue_sweep
    import hue_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP         = 12,
    parameter int TICK_CYCLES  = 12000,
    parameter int DWELL_TICKS  = 100,
    localparam int DUTY_W      = $clog2(PWM_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic [2:0]        phase,
    output logic              wrap
);

    localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(PWM_INTERVAL - 1);
    localparam logic [DUTY_W:0]   STEP_W = (DUTY_W + 1)'(STEP);

    logic tick;

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (tick)
    );

    logic [DUTY_W-1:0] ramp_q, ramp_d;
    phase_t            phase_q, phase_d;
    state_t            state_q, state_d;
    logic              wrap_q, wrap_d;
    logic [DUTY_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [DUTY_W:0]   ramp_sum;
    logic              at_max;
    logic              advance;

    assign at_max = (ramp_q == DMAX);

`ifdef HUE_DWELL_EN
    // Zero dwell collapses to the plain ramp behaviour.
    localparam bit USE_DWELL = (DWELL_TICKS > 0);
    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_TICKS - 1);

    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            dwell_done;

    assign dwell_done = (dwell_q == DW_LAST);
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
`ifdef HUE_DWELL_EN
        advance = tick && at_max &&
                  ((state_q == ST_RAMP && !USE_DWELL) ||
                   (state_q == ST_DWELL && dwell_done));
        if (tick) begin
            unique case (state_q)
                ST_RAMP:  if (at_max && USE_DWELL) state_d = ST_DWELL;
                ST_DWELL: if (dwell_done) state_d = ST_RAMP;
                default:  state_d = ST_RAMP;
            endcase
        end
`else
        advance = tick && at_max && (state_q == ST_RAMP);
`endif
    end

    // Datapath and registered-output values
    always_comb begin
        ramp_d   = ramp_q;
        phase_d  = phase_q;
        wrap_d   = 1'b0;
        ramp_sum = {1'b0, ramp_q} + STEP_W;
`ifdef HUE_DWELL_EN
        dwell_d = dwell_q;
        if (tick && state_q == ST_DWELL) begin
            dwell_d = dwell_done ? '0 : dwell_q + DW_W'(1);
        end
`endif
        if (advance) begin
            ramp_d  = '0;
            phase_d = phase_next(phase_q);
            wrap_d  = (phase_q == PH_B_DN);
        end else if (tick && !at_max) begin
            // Saturate so the last step lands exactly on full scale.
            ramp_d = (ramp_sum > {1'b0, DMAX}) ? DMAX
                                               : ramp_sum[DUTY_W-1:0];
        end

        r_d = '0;
        g_d = '0;
        b_d = '0;
        unique case (phase_d)
            PH_G_UP: begin r_d = DMAX;          g_d = ramp_d;        end
            PH_R_DN: begin r_d = DMAX - ramp_d; g_d = DMAX;          end
            PH_B_UP: begin g_d = DMAX;          b_d = ramp_d;        end
            PH_G_DN: begin g_d = DMAX - ramp_d; b_d = DMAX;          end
            PH_R_UP: begin r_d = ramp_d;        b_d = DMAX;          end
            PH_B_DN: begin r_d = DMAX;          b_d = DMAX - ramp_d; end
            default: begin r_d = DMAX;                               end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RAMP;
            ramp_q  <= '0;
            phase_q <= PH_G_UP;
            wrap_q  <= 1'b0;
            r_q     <= DMAX;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

`ifdef HUE_DWELL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`endif

    assign duty_r = r_q;
    assign duty_g = g_q;
    assign duty_b = b_q;
    assign phase  = phase_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_hue_sweep.sv
// Scoreboard bench for hue_sweep: PWM_INTERVAL=16, STEP=4, TICK_CYCLES=3.
// Build with HUE_DWELL_EN to exercise the DWELL_TICKS=2 variant.
module tb_hue_sweep;

    localparam int TC = 3;
`ifdef HUE_DWELL_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [2:0] ph;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] duty_r, duty_g, duty_b;
    logic [2:0] phase;
    logic       wrap;

    hue_sweep #(
        .PWM_INTERVAL(16),
        .STEP        (4),
        .TICK_CYCLES (TC),
        .DWELL_TICKS (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .duty_r(duty_r),
        .duty_g(duty_g),
        .duty_b(duty_b),
        .phase (phase),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int r, int g, int b, int ph, int w);
        exp_t e;
        e.r    = 4'(r);
        e.g    = 4'(g);
        e.b    = 4'(b);
        e.ph   = 3'(ph);
        e.wrap = 1'(w);
        return e;
    endfunction

    // Expanded tick index of base (no-dwell) tick k.
    function automatic int xi(int k);
        return k + D * (k / 5);
    endfunction

    exp_t RST;
    exp_t exp_cur;
    exp_t q[$];
    exp_t wheel[$];
    int   ecnt;
    int   checks;
    int   errors;

    initial begin
        RST     = mk(15, 0, 0, 0, 0);
        exp_cur = RST;
        ecnt    = 0;
        checks  = 0;
        errors  = 0;
    end

    task automatic check(string nm, exp_t want);
        exp_t got;
        got = exp_t'({duty_r, duty_g, duty_b, phase, wrap});
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t: got r=%0d g=%0d b=%0d ph=%0d wrap=%0d want r=%0d g=%0d b=%0d ph=%0d wrap=%0d",
                     nm, $time, got.r, got.g, got.b, got.ph, got.wrap,
                     want.r, want.g, want.b, want.ph, want.wrap);
        end
    endtask

    // Monitor: bench-side tick timing, pops on every expected tick,
    // otherwise checks that everything holds.
    always @(posedge clk) begin
        automatic logic due = 1'b0;
        if (rst_n && enable) begin
            ecnt++;
            if (ecnt == TC) begin
                ecnt = 0;
                due  = 1'b1;
            end
        end
        #1;
        if (!rst_n) begin
            exp_cur = RST;
            check("reset", RST);
        end else if (due) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tick_pop t=%0t: got tick with empty queue, want none", $time);
            end else begin
                exp_cur = q.pop_front();
                check("tick", exp_cur);
                exp_cur.wrap = 1'b0;
            end
        end else begin
            check("hold", exp_cur);
        end
    end

    always @(negedge rst_n) begin
        ecnt    = 0;
        exp_cur = RST;
        #1;
        check("async_reset", RST);
    end

    task automatic push_ticks(int n);
        for (int i = 0; i < n; i++) q.push_back(wheel[i]);
    endtask

    task automatic run(int n);
        enable = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t base[30];
        rst_n  = 1'b0;
        enable = 1'b1;
        base = '{
            mk(15, 4, 0, 0, 0), mk(15, 8, 0, 0, 0), mk(15,12, 0, 0, 0),
            mk(15,15, 0, 0, 0), mk(15,15, 0, 1, 0), mk(11,15, 0, 1, 0),
            mk( 7,15, 0, 1, 0), mk( 3,15, 0, 1, 0), mk( 0,15, 0, 1, 0),
            mk( 0,15, 0, 2, 0), mk( 0,15, 4, 2, 0), mk( 0,15, 8, 2, 0),
            mk( 0,15,12, 2, 0), mk( 0,15,15, 2, 0), mk( 0,15,15, 3, 0),
            mk( 0,11,15, 3, 0), mk( 0, 7,15, 3, 0), mk( 0, 3,15, 3, 0),
            mk( 0, 0,15, 3, 0), mk( 0, 0,15, 4, 0), mk( 4, 0,15, 4, 0),
            mk( 8, 0,15, 4, 0), mk(12, 0,15, 4, 0), mk(15, 0,15, 4, 0),
            mk(15, 0,15, 5, 0), mk(15, 0,11, 5, 0), mk(15, 0, 7, 5, 0),
            mk(15, 0, 3, 5, 0), mk(15, 0, 0, 5, 0), mk(15, 0, 0, 0, 1)
        };
        for (int i = 0; i < 30; i++) begin
            if ((i + 1) % 5 == 0) begin
                for (int j = 0; j < D; j++) wheel.push_back(base[i-1]);
            end
            wheel.push_back(base[i]);
        end

        repeat (3) @(negedge clk);
        push_ticks(xi(30));
        rst_n = 1'b1;

        // Into phase 2, one enabled cycle past a tick, then freeze.
        run(TC * xi(12) + 1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        run(TC * xi(30) - TC * xi(12) - 1);

        // Second wheel up to mid phase 4, then async reset pulse.
        push_ticks(xi(22));
        run(TC * xi(22));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);

        push_ticks(xi(6));
        run(TC * xi(6) + 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: got %0d pending, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hue_sweep.md
Name: hue_sweep

Overview:
- Duty-cycle source for the three RGB LED `pwm` instances; sits directly upstream of them.
- Walks a six-phase HSV-style colour wheel at full saturation and brightness.
- Drives `duty_r`, `duty_g` and `duty_b`, sized to the `pwm` `duty_cycle` port ($clog2(PWM_INTERVAL) bits).
- Advances by a fixed increment once per prescaled tick, so one full wheel takes 6 × (phase ticks) × TICK_CYCLES clocks.

Parameters:
- PWM_INTERVAL, 1200, period of the downstream `pwm`; DUTY_W = $clog2(PWM_INTERVAL); DUTY_MAX = PWM_INTERVAL-1.
- STEP, 12, ramp increment per tick; legal range 1..DUTY_MAX.
- TICK_CYCLES, 12000, clk cycles per tick (1 ms at 12 MHz); must be ≥ 1.
- DWELL_TICKS, 100, ticks held at each phase end; used only with HUE_DWELL_EN.

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  high = sweep runs; low = freeze prescaler, ramp, phase and outputs
- duty_r  out  DUTY_W  red duty to `pwm`
- duty_g  out  DUTY_W  green duty to `pwm`
- duty_b  out  DUTY_W  blue duty to `pwm`
- phase  out  3  current phase, 0..5
- wrap  out  1  one-cycle pulse when phase 5 completes and returns to 0

Behaviour:
- Reset is asynchronous and active-low: one clock; rst_n asserted low clears state immediately, regardless of clk.
  - Reset values: prescaler 0, ramp 0, phase 0, wrap 0, duty_r = DUTY_MAX, duty_g = 0, duty_b = 0.
  - Reset mid-sweep returns to these values at once; the sweep restarts from phase 0 after release.
- Prescaler counts 0..TICK_CYCLES-1 only while enable = 1.
  - tick is asserted in the cycle the count equals TICK_CYCLES-1; the count then wraps to 0.
  - TICK_CYCLES = 1 gives a tick every enabled cycle.
- Ramp update on tick:
  - If ramp < DUTY_MAX: ramp <= min(ramp + STEP, DUTY_MAX). Compute in DUTY_W+1 bits and saturate; no wrap-around.
  - If ramp == DUTY_MAX: phase advances (5 → 0), ramp <= 0. On 5 → 0, wrap pulses high for exactly that cycle.
- Per-phase channel mapping, with R = ramp and M = DUTY_MAX:
  - Phase 0: r = M, g = R, b = 0
  - Phase 1: r = M-R, g = M, b = 0
  - Phase 2: r = 0, g = M, b = R
  - Phase 3: r = 0, g = M-R, b = M
  - Phase 4: r = R, g = 0, b = M
  - Phase 5: r = M, g = 0, b = M-R
  - Channels are continuous across phase boundaries.
- Outputs are registered. Duty and phase change in the cycle after the tick cycle (latency 1); nothing changes between ticks.
- Phase length = ceil(DUTY_MAX/STEP) + 1 ticks.
- enable low on the tick cycle: no tick occurs. enable is sampled every cycle and has no pending memory.

Optional Feature:
- Macro: HUE_DWELL_EN.
- Defined: extra FSM state DWELL.
  - On a tick with ramp == DUTY_MAX, enter DWELL; outputs hold.
  - A dwell counter counts DWELL_TICKS ticks, then the block does the phase advance (and wrap, if applicable) and returns to RAMP.
  - DWELL_TICKS = 0 behaves as undefined.
  - Phase length becomes (ceil(DUTY_MAX/STEP) + 1) + DWELL_TICKS ticks.
- Undefined: FSM has the RAMP state only; DWELL_TICKS is ignored and no dwell counter is synthesised.

Decomposition:
- Package hue_pkg:
  - phase_t enum: PH_G_UP, PH_R_DN, PH_B_UP, PH_G_DN, PH_R_UP, PH_B_DN (0..5).
  - state_t enum: ST_RAMP, ST_DWELL.
- One natural sub-module: tick_prescaler (params TICK_CYCLES; ports clk, rst_n, enable, tick). Reusable by other timed stages.

Test Plan: (all with PWM_INTERVAL = 16 so DUTY_MAX = 15, DUTY_W = 4; STEP = 4; TICK_CYCLES = 3; enable = 1 unless stated)
- Reset released → r = 15, g = 0, b = 0, phase = 0. After ticks 1..4, g = 4, 8, 12, 15 (saturates, not 16 → 0), each one cycle after its tick.
- Continue to tick 5 → phase = 1, r = 15, g = 15. Tick 6 → r = 11. Boundary continuity holds.
- Run 30 ticks (90 clocks) from reset → wrap high for exactly 1 cycle, phase returns to 0, outputs equal the reset values.
- enable held low for 10 cycles mid-phase 2 → duty, phase and prescaler frozen. Next tick arrives exactly 3 enabled cycles after the prior one, counting across the gap.
- rst_n pulsed low asynchronously (between clk edges) in phase 4 → outputs immediately return to 15/0/0, phase 0. Sweep restarts on release.
- With HUE_DWELL_EN and DWELL_TICKS = 2 → g holds at 15 for 2 extra ticks before phase 1. Full wheel = 42 ticks. wrap pulses once.
